result_display: RTL

RESULT_DISPLAY -- requirements
Module: result_display

---
 rtl/result_display.sv | 109 ++++++++++
 1 files changed

// File: rtl/result_display.sv
// Latches a datapath result and shows it one 16-bit page at a time on a
// multiplexed 4-digit seven-segment display, with button paging and an MSB-page dot.
module result_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        result_valid,
    input  logic [63:0] result,
    input  logic [1:0]  size_sel,
    input  logic        page_btn,
    output logic        result_ack,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  page
);

    localparam int             CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [6:0]     SEG_DASH  = 7'b0111111;

    logic [CW-1:0] scan_q;
    logic [1:0]    digit_q;
    logic [63:0]   res_q;
    logic [1:0]    npage_q;
    logic          loaded_q;
    logic          btn_q;

    logic          btn_rise;
    logic          scan_wrap;
    logic [3:0]    nibble;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    // Active-low cathodes, bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    endfunction

    assign btn_rise  = page_btn & ~btn_q;
    assign scan_wrap = (scan_q == SCAN_LAST);
    // Bit offset 16*page + 4*digit is just the concatenation {page, digit, 2'b00}.
    assign nibble    = res_q[{page, digit_q, 2'b00} +: 4];

    always_comb begin
        an_d  = ~(4'b0001 << digit_q);
        seg_d = SEG_DASH;
        dp_d  = 1'b1;
        if (loaded_q) begin
            seg_d = hex_seg(nibble);
            dp_d  = !((digit_q == 2'd3) && (page == npage_q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q     <= '0;
            digit_q    <= '0;
            res_q      <= '0;
            npage_q    <= '0;
            loaded_q   <= 1'b0;
            btn_q      <= 1'b0;
            page       <= '0;
            result_ack <= 1'b0;
            an         <= 4'b1110;
            seg        <= SEG_DASH;
            dp         <= 1'b1;
        end else begin
            scan_q <= scan_wrap ? '0 : scan_q + CW'(1);
            if (scan_wrap) begin
                digit_q <= digit_q + 2'd1;
            end
            btn_q      <= page_btn;
            result_ack <= result_valid;
            // A capture in the same cycle as a button edge swallows the edge.
            if (result_valid) begin
                res_q    <= result;
                npage_q  <= size_sel;
                loaded_q <= 1'b1;
                page     <= '0;
            end else if (btn_rise && loaded_q) begin
                page <= (page == npage_q) ? 2'd0 : page + 2'd1;
            end
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule
